fpu_result_fifo: RTL
====================

// Module: fpu_result_fifo
// PURPOSE
//  Downstream stage of the FPU: captures each {data_out, status_out} result pair into a small FIFO.
//  A consumer drains results at its own pace, with registered read data.
//  Float format is 1 sign, 6 exponent (bias 31), 25 mantissa; 1.0=32'h3E000000, 2.0=32'h40000000.
//  Status bits: [3] EXACT, [2] OVERFLOW, [1] UNDERFLOW, [0] INEXACT.
// PARAMETERS
//  DEPTH     4   FIFO entries; power of two, >=2
//  DROP_W    8   width of saturating dropped-result counter
// PORTS
//  clock_100Khz  in   1        single system clock, rising edge
//  reset         in   1        asynchronous, active-low reset
//  res_valid_in  in   1        FPU result valid this cycle
//  data_in       in   32       FPU data_out
//  status_in     in   4        FPU status_out
//  rd_en         in   1        consumer pops head entry
//  rd_data       out  32       registered popped result
//  rd_status     out  4        registered popped status
//  rd_valid      out  1        1-cycle pulse: rd_data/rd_status updated
//  empty         out  1        no entries stored
//  full          out  1        DEPTH entries stored
//  count         out  $clog2(DEPTH)+1  entries stored
//  drop_cnt      out  DROP_W   results lost to full FIFO, saturating
//  clr_sticky    in   1        clears sticky_status (FPU_STICKY_STATUS_EN only)
//  sticky_status out  4        OR of accepted status_in since last clear
// BEHAVIOUR
//  - Reset (reset==0, async) values:
//    - pointers, count, rd_data, rd_status, rd_valid, drop_cnt, sticky_status = 0
//    - empty = 1, full = 0
//    - storage contents undefined
//  - Write: res_valid_in && (!full || pop) stores {data_in,status_in} at wr_ptr; wr_ptr++ mod DEPTH.
//  - Drop: res_valid_in && full && !pop -> entry discarded, drop_cnt++; holds at 2^DROP_W-1.
//  - Read: pop = rd_en && !empty.
//    - Next edge: rd_data/rd_status <= head, rd_valid <= 1, rd_ptr++ mod DEPTH.
//    - Read latency 1 cycle; rd_data holds its value until the next pop.
//  - rd_en while empty: ignored; rd_valid = 0, no pointer move, no error.
//  - Simultaneous write and pop:
//    - Full: both occur, count unchanged, no drop.
//    - Empty: write accepted, pop ignored (new entry is not bypassed), count -> 1.
//  - count updates by +1 (write only), -1 (pop only), 0 (both/neither); empty/full derived from it.
//  - Pointers carry no extra wrap bit; count is the sole occupancy source.
//  - Reset asserted mid-operation: all contents lost, outputs go to reset values immediately.
//  - Ordering strictly FIFO; no reordering, no data modification.
// CONFIGURATION
//  FPU_STICKY_STATUS_EN defined:
//    - sticky_status <= sticky_status | status_in on every accepted write.
//    - clr_sticky=1 clears it next edge; a write on the same edge still ORs in (clear then set).
//    - Dropped results do not update sticky_status.
//  FPU_STICKY_STATUS_EN undefined:
//    - sticky_status tied to 4'b0; clr_sticky ignored; no sticky flops.
// TESTING
//  1 Reset: drive reset=0 mid-run with 2 entries stored -> count=0, empty=1, rd_valid=0, drop_cnt=0.
//  2 Write 32'h3E000000/4'b1000, then 32'h40000000/4'b1000; pop twice:
//    rd_data 3E000000 then 40000000, each 1 cycle after rd_en.
//  3 Fill with 4 writes, then a 5th write (32'h40800000) -> full=1, drop_cnt=1, count=4.
//    Drain -> first 4 values returned in order.
//  4 Full + res_valid_in + rd_en same cycle -> count stays 4, drop_cnt unchanged.
//    Oldest value popped; new value emerges after 3 more pops.
//  5 Empty + rd_en + write 32'h3E000000 same cycle -> rd_valid=0, count=1.
//    Next pop returns 3E000000; rd_en on empty -> rd_valid stays 0.
//  6 FPU_STICKY_STATUS_EN: accept status 4'b0100 then 4'b0001 -> sticky=4'b0101.
//    clr_sticky -> 4'b0000; without the macro sticky stays 0.
//    Also wrap pointers with >8 writes/pops; order preserved.

Source files
------------

// File: rtl/fpu_result_fifo_if.sv
// Result-capture and drain signals between the FPU, the result FIFO and its consumer.
// The producer/consumer side uses the master modport; the FIFO uses the slave modport.
interface fpu_result_fifo_if #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
);
    logic                      res_valid_in;
    logic [31:0]               data_in;
    logic [3:0]                status_in;
    logic                      rd_en;
    logic                      clr_sticky;
    logic [31:0]               rd_data;
    logic [3:0]                rd_status;
    logic                      rd_valid;
    logic                      empty;
    logic                      full;
    logic [$clog2(DEPTH):0]    count;
    logic [DROP_W-1:0]         drop_cnt;
    logic [3:0]                sticky_status;

    modport master (
        output res_valid_in, data_in, status_in, rd_en, clr_sticky,
        input  rd_data, rd_status, rd_valid, empty, full, count, drop_cnt, sticky_status
    );

    modport slave (
        input  res_valid_in, data_in, status_in, rd_en, clr_sticky,
        output rd_data, rd_status, rd_valid, empty, full, count, drop_cnt, sticky_status
    );
endinterface

// File: rtl/fpu_result_fifo.sv
// FIFO capturing FPU {data, status} results with registered pop data and a saturating drop counter.
// Optional sticky status accumulation is enabled by defining FPU_STICKY_STATUS_EN.
module fpu_result_fifo #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic               clock_100Khz,
    input  logic               reset,
    fpu_result_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic [31:0]       rd_data_q;
    logic [3:0]        rd_status_q;
    logic              rd_valid_q;
    logic [DROP_W-1:0] drop_q;
    logic [35:0]       mem [DEPTH];

    logic is_empty;
    logic is_full;
    logic pop;
    logic push;
    logic drop;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    // A pop frees the head slot on the same edge, so a full FIFO can still accept.
    assign pop  = bus.rd_en && !is_empty;
    assign push = bus.res_valid_in && (!is_full || pop);
    assign drop = bus.res_valid_in && is_full && !pop;

    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_status_q <= '0;
            rd_valid_q  <= 1'b0;
            drop_q      <= '0;
        end else begin
            rd_valid_q <= pop;
            if (pop) begin
                {rd_data_q, rd_status_q} <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (drop && (drop_q != '1)) begin
                drop_q <= drop_q + DROP_W'(1);
            end
        end
    end

    // Storage is intentionally not reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clock_100Khz) begin
        if (push) begin
            mem[wr_ptr] <= {bus.data_in, bus.status_in};
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_status = rd_status_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.count     = count_q;
    assign bus.drop_cnt  = drop_q;

`ifdef FPU_STICKY_STATUS_EN
    logic [3:0] sticky_q;

    // Clear takes priority over history, but a write on the same edge still lands.
    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= (bus.clr_sticky ? 4'b0000 : sticky_q) | (push ? bus.status_in : 4'b0000);
        end
    end

    assign bus.sticky_status = sticky_q;
`else
    logic unused_clr_sticky;

    assign unused_clr_sticky  = bus.clr_sticky;
    assign bus.sticky_status  = 4'b0000;
`endif

endmodule
